// File: rtl/entity_line_scanner.sv
// entity_line_scanner: per-scanline entity selector.
// During each horizontal blank the entity list is walked one entity per cycle
// and up to MAX_PER_LINE entities that intersect the next line are latched
// into shadow slots. The shadow set is promoted to the active set on the last
// column of the line. During active video the pixel is resolved against the
// active slots by fixed priority (lowest slot = lowest entity index).
module entity_line_scanner #(
    parameter int NUM_ENTITIES   = 9,
    parameter int MAX_PER_LINE   = 4,
    parameter logic [NUM_ENTITIES-1:0] FLIP_MASK = 9'b110000000,
    parameter int TILE_SIZE      = 8,
    parameter int UPSCALE_FACTOR = 5,
    parameter int H_ACTIVE       = 640,
    parameter int H_TOTAL        = 800,
    parameter int V_ACTIVE       = 480,
    parameter int V_TOTAL        = 525,
    parameter int ID_W           = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_ENTITIES*(ID_W+10)-1:0]      entities,
    input  logic [9:0]                             counter_H,
    input  logic [9:0]                             counter_V,
    output logic [$clog2(TILE_SIZE)+ID_W+2-1:0]    out_entity,
    output logic                                   out_valid,
    output logic                                   line_overflow
);

    localparam int ROW_W    = $clog2(TILE_SIZE);
    localparam int OUT_W    = ROW_W + ID_W + 2;
    localparam int EW       = ID_W + 10;
    localparam int TILE_LEN = TILE_SIZE * UPSCALE_FACTOR;
    localparam int IDX_W    = (NUM_ENTITIES > 1) ? $clog2(NUM_ENTITIES) : 1;
    localparam int SLOT_W   = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    // Unpacked view of the flat entity bus
    logic [ID_W-1:0] ent_id     [NUM_ENTITIES];
    logic [1:0]      ent_orient [NUM_ENTITIES];
    logic [3:0]      ent_row    [NUM_ENTITIES];
    logic [3:0]      ent_col    [NUM_ENTITIES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTITIES; gi++) begin : g_unpack
            assign ent_col[gi]    = entities[gi*EW      +: 4];
            assign ent_row[gi]    = entities[gi*EW + 4  +: 4];
            assign ent_orient[gi] = entities[gi*EW + 8  +: 2];
            assign ent_id[gi]     = entities[gi*EW + 10 +: ID_W];
        end
    endgenerate

    state_t          state_q;
    logic [IDX_W-1:0] idx_q;
    logic [9:0]      target_q;

    // Shadow slot set (written by the scan)
    logic             sh_valid_q  [MAX_PER_LINE];
    logic [3:0]       sh_col_q    [MAX_PER_LINE];
    logic [ID_W-1:0]  sh_id_q     [MAX_PER_LINE];
    logic [1:0]       sh_orient_q [MAX_PER_LINE];
    logic [ROW_W-1:0] sh_row_q    [MAX_PER_LINE];
    logic             sh_ovf_q;

    // Active slot set (read by the pixel resolver)
    logic             act_valid_q  [MAX_PER_LINE];
    logic [3:0]       act_col_q    [MAX_PER_LINE];
    logic [ID_W-1:0]  act_id_q     [MAX_PER_LINE];
    logic [1:0]       act_orient_q [MAX_PER_LINE];
    logic [ROW_W-1:0] act_row_q    [MAX_PER_LINE];
    logic             act_ovf_q;

    logic [OUT_W-1:0] out_entity_q, out_entity_d;
    logic             out_valid_q, out_valid_d;

    // Hit test for the entity currently visited by the scan
    logic             scan_hit;
    logic [ROW_W-1:0] scan_row;
    logic [11:0]      t_ext, row_base, row_off;
    always_comb begin
        t_ext    = 12'(target_q);
        row_base = 12'(ent_row[idx_q]) * 12'(TILE_LEN);
        row_off  = t_ext - row_base;
        scan_hit = (ent_id[idx_q] != '1) && (t_ext < 12'(V_ACTIVE)) &&
                   (t_ext >= row_base) && (t_ext < row_base + 12'(TILE_LEN));
        scan_row = ROW_W'(row_off / 12'(UPSCALE_FACTOR));
        if (FLIP_MASK[idx_q]) scan_row = ~scan_row;
    end

    // Lowest free shadow slot
    logic              free_found;
    logic [SLOT_W-1:0] free_slot;
    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
            if (!sh_valid_q[s]) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(s);
            end
        end
    end

    // Scan FSM: start at the start of horizontal blank, fill shadow slots
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            target_q <= '0;
            sh_ovf_q <= 1'b0;
            for (int s = 0; s < MAX_PER_LINE; s++) begin
                sh_valid_q[s]  <= 1'b0;
                sh_col_q[s]    <= '0;
                sh_id_q[s]     <= '0;
                sh_orient_q[s] <= '0;
                sh_row_q[s]    <= '0;
            end
        end else begin
            case (state_q)
                S_SCAN: begin
                    if (scan_hit) begin
                        if (free_found) begin
                            sh_valid_q[free_slot]  <= 1'b1;
                            sh_col_q[free_slot]    <= ent_col[idx_q];
                            sh_id_q[free_slot]     <= ent_id[idx_q];
                            sh_orient_q[free_slot] <= ent_orient[idx_q];
                            sh_row_q[free_slot]    <= scan_row;
                        end else begin
                            sh_ovf_q <= 1'b1;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_ENTITIES - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    if (counter_H == 10'(H_ACTIVE)) begin
                        state_q  <= S_SCAN;
                        idx_q    <= '0;
                        target_q <= (counter_V == 10'(V_TOTAL - 1)) ? 10'd0
                                                                    : counter_V + 10'd1;
                        sh_ovf_q <= 1'b0;
                        for (int s = 0; s < MAX_PER_LINE; s++) begin
                            sh_valid_q[s] <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Promote shadow slots to the active set on the last column of the line
    always_ff @(posedge clk) begin
        if (reset) begin
            act_ovf_q <= 1'b0;
            for (int s = 0; s < MAX_PER_LINE; s++) begin
                act_valid_q[s]  <= 1'b0;
                act_col_q[s]    <= '0;
                act_id_q[s]     <= '0;
                act_orient_q[s] <= '0;
                act_row_q[s]    <= '0;
            end
        end else if (counter_H == 10'(H_TOTAL - 1)) begin
            act_ovf_q <= sh_ovf_q;
            for (int s = 0; s < MAX_PER_LINE; s++) begin
                act_valid_q[s]  <= sh_valid_q[s];
                act_col_q[s]    <= sh_col_q[s];
                act_id_q[s]     <= sh_id_q[s];
                act_orient_q[s] <= sh_orient_q[s];
                act_row_q[s]    <= sh_row_q[s];
            end
        end
    end

    // Pixel resolve: lowest-numbered matching active slot wins
    logic [11:0] h_ext, col_base;
    always_comb begin
        h_ext        = 12'(counter_H);
        col_base     = '0;
        out_entity_d = '1;
        out_valid_d  = 1'b0;
        for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
            col_base = 12'(act_col_q[s]) * 12'(TILE_LEN);
            if (act_valid_q[s] && (h_ext < 12'(H_ACTIVE)) &&
                (h_ext >= col_base) && (h_ext < col_base + 12'(TILE_LEN))) begin
                out_entity_d = {act_row_q[s], act_id_q[s], act_orient_q[s]};
                out_valid_d  = 1'b1;
            end
        end
    end

    // Registered output word, one cycle after the pixel position
    always_ff @(posedge clk) begin
        if (reset) begin
            out_entity_q <= '1;
            out_valid_q  <= 1'b0;
        end else begin
            out_entity_q <= out_entity_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_entity    = out_entity_q;
    assign out_valid     = out_valid_q;
    assign line_overflow = act_ovf_q;

endmodule

// File: tb/tb_entity_line_scanner.sv
// Directed testbench for entity_line_scanner.
module tb_entity_line_scanner;

    localparam int N  = 9;
    localparam int EW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic [N*EW-1:0] entities;
    logic [9:0]    counter_H;
    logic [9:0]    counter_V;
    logic [8:0]    out_entity;
    logic          out_valid;
    logic          line_overflow;

    int total = 0;
    int bad   = 0;

    entity_line_scanner dut (
        .clk           (clk),
        .reset         (reset),
        .entities      (entities),
        .counter_H     (counter_H),
        .counter_V     (counter_V),
        .out_entity    (out_entity),
        .out_valid     (out_valid),
        .line_overflow (line_overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [13:0] ent(input int id, input int orient, input int row, input int col);
        return {4'(id), 2'(orient), 4'(row), 4'(col)};
    endfunction

    task automatic set_ent(input int i, input logic [13:0] e);
        entities[i*EW +: EW] = e;
    endtask

    // Run the horizontal blank of line prev_v, then sit at column 0 of the next line
    task automatic line_prep(input int prev_v);
        counter_V = 10'(prev_v);
        for (int h = 640; h < 800; h++) begin
            counter_H = 10'(h);
            cyc();
        end
        counter_V = (prev_v == 524) ? 10'd0 : 10'(prev_v + 1);
        counter_H = 10'd0;
    endtask

    task automatic probe(input string tag, input int h, input logic [8:0] exp_e, input logic exp_v);
        counter_H = 10'(h);
        cyc();
        chk({tag, "_ent"}, 16'(out_entity), 16'(exp_e));
        chk({tag, "_vld"}, 16'(out_valid), 16'(exp_v));
    endtask

    initial begin
        reset     = 1'b1;
        counter_H = 10'd0;
        counter_V = 10'd0;
        entities  = '1;
        repeat (3) cyc();
        chk("rst_ent", 16'(out_entity), 16'h1FF);
        chk("rst_vld", 16'(out_valid), 16'h0);
        chk("rst_ovf", 16'(line_overflow), 16'h0);
        reset = 1'b0;

        // Basic hit: index 0, ID 3, orient 1, tile row 2, col 1
        set_ent(0, ent(3, 1, 2, 1));
        line_prep(86);
        probe("basic_h40", 40, 9'h04D, 1'b1);
        probe("basic_h79", 79, 9'h04D, 1'b1);
        probe("basic_h80", 80, 9'h1FF, 1'b0);
        probe("basic_h39", 39, 9'h1FF, 1'b0);
        line_prep(118);
        probe("basic_l119", 40, 9'h1CD, 1'b1);
        line_prep(119);
        probe("basic_l120", 40, 9'h1FF, 1'b0);

        // Flip: same entity at index 7
        entities = '1;
        set_ent(7, ent(3, 1, 2, 1));
        line_prep(86);
        probe("flip_h40", 40, 9'h18D, 1'b1);

        // Priority: index 2 (ID 5) beats index 4 (ID 6)
        entities = '1;
        set_ent(2, ent(5, 0, 2, 1));
        set_ent(4, ent(6, 0, 2, 1));
        line_prep(86);
        probe("prio_h40", 40, 9'h054, 1'b1);
        probe("prio_h79", 79, 9'h054, 1'b1);
        chk("prio_ovf", 16'(line_overflow), 16'h0);

        // Exactly four hits: no overflow
        entities = '1;
        for (int i = 0; i < 4; i++) set_ent(i, ent(i + 1, 0, 3, i));
        line_prep(129);
        chk("four_ovf", 16'(line_overflow), 16'h0);
        probe("four_c3", 120, 9'h090, 1'b1);

        // Five hits: fifth dropped, overflow for line 130
        set_ent(4, ent(5, 0, 3, 4));
        line_prep(129);
        chk("ovf_flag", 16'(line_overflow), 16'h1);
        probe("ovf_c0", 0, 9'h084, 1'b1);
        probe("ovf_c3", 120, 9'h090, 1'b1);
        probe("ovf_c4", 160, 9'h1FF, 1'b0);
        entities = '1;
        line_prep(130);
        chk("ovf_next", 16'(line_overflow), 16'h0);

        // Wrap: scan on line 524 targets line 0
        set_ent(0, ent(9, 2, 0, 0));
        line_prep(524);
        probe("wrap_h0", 0, 9'h026, 1'b1);
        probe("wrap_h39", 39, 9'h026, 1'b1);
        probe("wrap_h40", 40, 9'h1FF, 1'b0);
        line_prep(479);
        probe("blank_l480", 0, 9'h1FF, 1'b0);

        // Reset in the middle of the scan on line 86
        entities = '1;
        set_ent(0, ent(3, 1, 2, 1));
        counter_V = 10'd86;
        for (int h = 640; h < 643; h++) begin
            counter_H = 10'(h);
            cyc();
        end
        counter_H = 10'd643;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int h = 644; h < 800; h++) begin
            counter_H = 10'(h);
            cyc();
        end
        counter_V = 10'd87;
        probe("rstmid_l87", 40, 9'h1FF, 1'b0);
        line_prep(87);
        probe("rstmid_l88", 40, 9'h04D, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/entity_line_scanner.md
Name: entity_line_scanner

Overview:
Parametrised, pipelined successor to the frame builder's combinational entity detector-combination stage. The detector no longer compares every entity against every pixel. Instead, during each horizontal blank it scans the entity list once, one entity per cycle, and latches up to MAX_PER_LINE entities that intersect the next scanline into slot registers. During active video it resolves the pixel against those slots by fixed priority and emits a registered {tile row, ID, orientation} word to the sprite ROM stage.

Parameters:
NUM_ENTITIES, 9, entities in the flat input bus; must be <= H_TOTAL-H_ACTIVE
MAX_PER_LINE, 4, slot registers per scanline
FLIP_MASK, 9'b110000000, bit i=1 means entity i is vertically flipped
TILE_SIZE, 8, tile edge in source pixels (power of 2); ROW_W=log2(TILE_SIZE)
UPSCALE_FACTOR, 5, screen pixels per source pixel; TILE_LEN=TILE_SIZE*UPSCALE_FACTOR
H_ACTIVE, 640, visible columns
H_TOTAL, 800, columns per line
V_ACTIVE, 480, visible lines
V_TOTAL, 525, lines per frame
ID_W, 4, entity ID width; all-ones ID = unused entity

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
entities  input  NUM_ENTITIES*(ID_W+10)  packed entities; entity i at [i*(ID_W+10) +: ID_W+10] = {ID, orient[1:0], tile_row[3:0], tile_col[3:0]}
counter_H  input  10  current pixel column
counter_V  input  10  current line
out_entity  output  ROW_W+ID_W+2  {row, ID, orient}; all ones when no hit
out_valid  output  1  high when out_entity is a hit
line_overflow  output  1  more than MAX_PER_LINE entities hit the line now being displayed

Behaviour:
- One clock; reset is synchronous and active-high, on clk/reset.
- Reset values: FSM=IDLE, all slots invalid, out_entity all ones, out_valid=0, line_overflow=0, scan index 0.
- FSM states:
  - IDLE -> SCAN when counter_H==H_ACTIVE.
  - SCAN: visits index i=0..NUM_ENTITIES-1, one per cycle, sampling entity i in that cycle.
  - SCAN -> DONE after the last index.
  - DONE -> SCAN at the next counter_H==H_ACTIVE.
- Target line T = (counter_V==V_TOTAL-1) ? 0 : counter_V+1, latched on entering SCAN.
- Shadow slots: SCAN writes a shadow set. The shadow set copies to the active set when counter_H==H_TOTAL-1.
- Hit rule, in SCAN: entity i is a hit if all of these hold:
  - ID != all ones
  - T < V_ACTIVE
  - tile_row*TILE_LEN <= T < tile_row*TILE_LEN + TILE_LEN
- A hit fills the lowest free shadow slot.
  - Slot stores col, ID, orient.
  - Slot stores row = (T mod TILE_LEN)/UPSCALE_FACTOR, truncated to ROW_W bits. If FLIP_MASK[i], row is the bitwise inverse.
- A hit with no free slot sets the shadow overflow bit; that entity is dropped. Shadow slots and the overflow bit clear on entering SCAN.
- line_overflow follows the active copy of the overflow bit.
- Pixel resolve, every cycle:
  - A slot matches if valid, counter_H < H_ACTIVE, and col*TILE_LEN <= counter_H < col*TILE_LEN+TILE_LEN.
  - The lowest-numbered matching slot wins, i.e. the lowest entity index wins. This replaces bitwise-AND merging.
- Latency: exactly 1 cycle. out_entity/out_valid at cycle t+1 reflect counter_H/counter_V at cycle t. A miss registers all ones and out_valid=0.
- Entity changes mid-line affect only lines whose scan samples them.
- Reset mid-SCAN aborts the scan and clears both slot sets. Lines before the next completed scan output all ones.
- Tile rows >= 12 never hit.

Test Plan:
- Basic hit: entity0 = ID 3, orient 1, tile row 2, col 1; others ID F.
  - Line 87, counter_H=40 -> next cycle out_entity=0x04D (row 1), out_valid=1.
  - counter_H=80 -> 0x1FF.
- Flip: same entity placed at index 7, line 87, H=40 -> out_entity=0x18D (row 6).
- Priority: index 2 = ID 5 and index 4 = ID 6, both tile 0x21 -> ID 5 output over columns 40..79.
- Overflow: indices 0..4 all on tile row 3, cols 0..4, line 130.
  - Cols 0..3 display; col 4 (H 160..199) outputs 0x1FF.
  - line_overflow=1 for line 130 only.
- Wrap: entity tile 0x00, line 524 scan -> line 0, H=0..39 shows row 0. Line 480 (blank) outputs 0x1FF.
- Reset mid-scan: pulse reset at counter_H=H_ACTIVE+3 on line 86.
  - Line 87 outputs all 0x1FF, out_valid=0.
  - Line 88 displays normally (row 1).
